// File: rtl/mdu_pkg.sv
// Shared op encodings, default latencies and the latched-request payload for the MULT/DIV unit.
package mdu_pkg;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int unsigned MDU_XLEN        = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  typedef struct packed {
    logic [2:0]          op;
    logic [MDU_XLEN-1:0] a;
    logic [MDU_XLEN-1:0] b;
  } mdu_req_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational quotient/remainder with sign fix-up: quotient truncates toward zero,
// remainder takes the dividend's sign. Divide-by-zero output is don't-care.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic                sign,
  input  logic [MDU_XLEN-1:0] dividend,
  input  logic [MDU_XLEN-1:0] divisor,
  output logic [MDU_XLEN-1:0] quot,
  output logic [MDU_XLEN-1:0] rem
);

  logic                neg_n;
  logic                neg_d;
  logic [MDU_XLEN-1:0] mag_n;
  logic [MDU_XLEN-1:0] mag_d;
  logic [MDU_XLEN-1:0] q_u;
  logic [MDU_XLEN-1:0] r_u;

  always_comb begin
    neg_n = sign & dividend[MDU_XLEN-1];
    neg_d = sign & divisor[MDU_XLEN-1];
    mag_n = neg_n ? (~dividend + MDU_XLEN'(1)) : dividend;
    mag_d = neg_d ? (~divisor + MDU_XLEN'(1)) : divisor;
    q_u   = '0;
    r_u   = '0;
    if (mag_d != '0) begin
      q_u = mag_n / mag_d;
      r_u = mag_n % mag_d;
    end
    // 0x80000000 / -1 wraps back to 0x80000000 through the negate
    quot = (neg_n ^ neg_d) ? (~q_u + MDU_XLEN'(1)) : q_u;
    rem  = neg_n ? (~r_u + MDU_XLEN'(1)) : r_u;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit with fixed latencies.
// Optional MDU_MADD_EN enables MADD/MADDU accumulate into {HI,LO}.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [MDU_XLEN-1:0] A,
  input  logic [MDU_XLEN-1:0] B,
  output logic                busy,
  output logic [MDU_XLEN-1:0] HI,
  output logic [MDU_XLEN-1:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [0:0]          next_state;
  logic [CNT_W-1:0]    cnt;
  mdu_req_t            req;
  logic                long_op_c;
  logic                accept_c;
  logic                done_c;
  logic [CNT_W-1:0]    lat_c;
  logic [2*MDU_XLEN-1:0] mul_a_c;
  logic [2*MDU_XLEN-1:0] mul_b_c;
  logic [2*MDU_XLEN-1:0] prod_c;
  logic [2*MDU_XLEN-1:0] acc_c;
  logic [MDU_XLEN-1:0] quot;
  logic [MDU_XLEN-1:0] rem;

  assign busy = (state == RUN);

  // Ops that occupy the unit for a full latency window
  always_comb begin
    long_op_c = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op_c = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  long_op_c = 1'b1;
`endif
      default:                            long_op_c = 1'b0;
    endcase
    lat_c = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: if (start && long_op_c) begin
        accept_c   = 1'b1;
        next_state = RUN;
      end
      RUN: if (cnt == CNT_W'(1)) begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // op[0] selects the unsigned flavour for MULTU/MADDU
  always_comb begin
    mul_a_c = req.op[0] ? {{MDU_XLEN{1'b0}}, req.a} : {{MDU_XLEN{req.a[MDU_XLEN-1]}}, req.a};
    mul_b_c = req.op[0] ? {{MDU_XLEN{1'b0}}, req.b} : {{MDU_XLEN{req.b[MDU_XLEN-1]}}, req.b};
    prod_c  = mul_a_c * mul_b_c;
    acc_c   = prod_c;
`ifdef MDU_MADD_EN
    if (req.op[2]) acc_c = {HI, LO} + prod_c;
`endif
  end

  mdu_div_core u_div (
    .sign     (~req.op[0]),
    .dividend (req.a),
    .divisor  (req.b),
    .quot     (quot),
    .rem      (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      req <= '0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      if (accept_c) begin
        cnt    <= lat_c;
        req.op <= op;
        req.a  <= A;
        req.b  <= B;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == IDLE && start && op == OP_MTHI) HI <= A;
      if (state == IDLE && start && op == OP_MTLO) LO <= A;
      // Divide by zero leaves HI/LO untouched
      if (done_c) begin
        if (is_div_op(req.op)) begin
          if (req.b != '0) begin
            HI <= rem;
            LO <= quot;
          end
        end else begin
          {HI, LO} <= acc_c;
        end
      end
    end
  end

endmodule
